pixel_plot_receiver: RTL and testbench

Receiving end of the pixel-plot interface driven by the game pixel renderer. It accepts `(x, y, color)` triples qualified by `plotPixel` and buffers them in a small FIFO. It translates each triple to a linear framebuffer address and writes it into the framebuffer memory port under a ready/valid handshake. It also reports end-of-frame and error status to the game controller. It sits between the renderer and the framebuffer RAM in the display path.

---
 rtl/pixel_plot_receiver.sv | 178 +++++++++++++++++
 tb/tb_pixel_plot_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_receiver.sv
// pixel_plot_receiver
// Receives (x, y, color) plots from the pixel renderer, range-checks them, converts
// them to linear framebuffer addresses and queues them in a small FIFO. The FIFO head
// is written to the framebuffer under a ready/valid handshake.
//
// Ports:
//   clk, resetn            system clock (rising edge), asynchronous active-low reset
//   x, y, color, plotPixel pixel plot input, one pixel per cycle with plotPixel high
//   clearStatus            synchronous clear of overflow and dropCount
//   fb_addr, fb_data       framebuffer write address / data (head entry, registered)
//   fb_we, fb_ready        write valid / memory ready handshake
//   frameDone              one-cycle pulse after the (XMAX, YMAX) pixel is written
//   overflow               sticky: an in-range plot was lost to a full FIFO
//   dropCount              saturating count of rejected plots
module pixel_plot_receiver #(
    parameter int unsigned XMAX   = 159,
    parameter int unsigned YMAX   = 119,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [2:0]        color,
    input  logic              plotPixel,
    input  logic              clearStatus,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              frameDone,
    output logic              overflow,
    output logic [7:0]        dropCount
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StEmpty, StStreaming, StFull} fifoState_t;

    fifoState_t        stateQ, stateD;
    logic [PtrW-1:0]   rdPtrQ, wrPtrQ, rdNext;
    logic [CntW-1:0]   countQ, countD;
    logic [ADDR_W-1:0] headAddrQ, headAddrD;
    logic [2:0]        headColorQ, headColorD;
    logic              headLastQ, headLastD;
    logic              frameDoneQ;
    logic              overflowQ, overflowD;
    logic [7:0]        dropCntQ, dropCntD;

    logic [ADDR_W-1:0] memAddr  [DEPTH];
    logic [2:0]        memColor [DEPTH];
    logic              memLast  [DEPTH];

    logic              inRange, isLast, push, pop, lostFull, drop;
    logic [ADDR_W-1:0] pixAddr;

    assign inRange = (32'(x) <= XMAX) && (32'(y) <= YMAX);
    assign isLast  = (32'(x) == XMAX) && (32'(y) == YMAX);
    assign pixAddr = ADDR_W'(y) * ADDR_W'(XMAX + 1) + ADDR_W'(x);

    assign pop      = fb_we && fb_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = plotPixel && inRange && ((stateQ != StFull) || pop);
    assign lostFull = plotPixel && inRange && !push;
    assign drop     = plotPixel && !push;
    assign rdNext   = rdPtrQ + PtrW'(1);

    // State register and FIFO bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ     <= StEmpty;
            rdPtrQ     <= '0;
            wrPtrQ     <= '0;
            countQ     <= '0;
            headAddrQ  <= '0;
            headColorQ <= '0;
            headLastQ  <= 1'b0;
            frameDoneQ <= 1'b0;
            overflowQ  <= 1'b0;
            dropCntQ   <= '0;
        end else begin
            stateQ     <= stateD;
            countQ     <= countD;
            headAddrQ  <= headAddrD;
            headColorQ <= headColorD;
            headLastQ  <= headLastD;
            frameDoneQ <= pop && headLastQ;
            overflowQ  <= overflowD;
            dropCntQ   <= dropCntD;
            if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
            if (pop)  rdPtrQ <= rdNext;
        end
    end

    // Storage array needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            memAddr[wrPtrQ]  <= pixAddr;
            memColor[wrPtrQ] <= color;
            memLast[wrPtrQ]  <= isLast;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StEmpty: begin
                if (push) stateD = StStreaming;
            end
            StStreaming: begin
                if (push && !pop && (countQ == CntW'(DEPTH - 1))) stateD = StFull;
                else if (pop && !push && (countQ == CntW'(1)))    stateD = StEmpty;
            end
            StFull: begin
                if (pop && !push) stateD = StStreaming;
            end
            default: stateD = StEmpty;
        endcase
    end

    // Occupancy, head register and status next-state
    always_comb begin
        countD = countQ;
        unique case ({push, pop})
            2'b10:   countD = countQ + CntW'(1);
            2'b01:   countD = countQ - CntW'(1);
            default: countD = countQ;
        endcase

        // Head entry is kept in its own registers so the write port is glitch-free;
        // a push into a one-entry FIFO that is popping bypasses the array.
        headAddrD  = headAddrQ;
        headColorD = headColorQ;
        headLastD  = headLastQ;
        if (pop) begin
            if (countQ > CntW'(1)) begin
                headAddrD  = memAddr[rdNext];
                headColorD = memColor[rdNext];
                headLastD  = memLast[rdNext];
            end else if (push) begin
                headAddrD  = pixAddr;
                headColorD = color;
                headLastD  = isLast;
            end
        end else if (push && (stateQ == StEmpty)) begin
            headAddrD  = pixAddr;
            headColorD = color;
            headLastD  = isLast;
        end

        // A drop in the same cycle as a clear takes precedence over the clear.
        overflowD = overflowQ;
        if (lostFull)         overflowD = 1'b1;
        else if (clearStatus) overflowD = 1'b0;

        dropCntD = dropCntQ;
        if (drop) begin
            if (clearStatus)            dropCntD = 8'd1;
            else if (dropCntQ != 8'hFF) dropCntD = dropCntQ + 8'd1;
        end else if (clearStatus) begin
            dropCntD = '0;
        end
    end

    // Outputs
    always_comb begin
        fb_we     = (stateQ != StEmpty);
        fb_addr   = headAddrQ;
        fb_data   = headColorQ;
        frameDone = frameDoneQ;
        overflow  = overflowQ;
        dropCount = dropCntQ;
    end

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Directed bench for pixel_plot_receiver with default parameters (160x120, DEPTH=4).
module tb_pixel_plot_receiver;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  x, y;
    logic [2:0]  color;
    logic        plotPixel, clearStatus, fb_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we, frameDone, overflow;
    logic [7:0]  dropCount;

    int nVec = 0;
    int nMis = 0;

    pixel_plot_receiver dut (
        .clk         (clk),
        .resetn      (resetn),
        .x           (x),
        .y           (y),
        .color       (color),
        .plotPixel   (plotPixel),
        .clearStatus (clearStatus),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .frameDone   (frameDone),
        .overflow    (overflow),
        .dropCount   (dropCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setPix(input int px, input int py, input int pc);
        x         = px[7:0];
        y         = py[7:0];
        color     = pc[2:0];
        plotPixel = 1'b1;
    endtask

    task automatic doReset();
        resetn      = 1'b0;
        plotPixel   = 1'b0;
        clearStatus = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int expAddr, writeCnt, addrBad, fdCnt, fdBad, spurious;
        x = '0; y = '0; color = '0; plotPixel = 1'b0; clearStatus = 1'b0;
        fb_ready = 1'b1;
        resetn   = 1'b0;
        step();

        // Reset state
        check("rst_fb_we",     fb_we,     0);
        check("rst_fb_addr",   fb_addr,   0);
        check("rst_fb_data",   fb_data,   0);
        check("rst_frameDone", frameDone, 0);
        check("rst_overflow",  overflow,  0);
        check("rst_dropCount", dropCount, 0);
        resetn = 1'b1;
        step();

        // Single pixel (3,2) -> 2*160+3 = 323
        setPix(3, 2, 5);
        step();
        plotPixel = 1'b0;
        check("single_we",    fb_we,     1);
        check("single_addr",  fb_addr,   323);
        check("single_data",  fb_data,   5);
        check("single_fdone", frameDone, 0);
        step();
        check("single_we_off",  fb_we,     0);
        check("single_fdone2",  frameDone, 0);
        check("single_drops",   dropCount, 0);

        // Full frame on alternating cycles
        doReset();
        fb_ready = 1'b1;
        expAddr = 0; writeCnt = 0; addrBad = 0; fdCnt = 0; fdBad = 0;
        for (int py = 0; py < 120; py++) begin
            for (int px = 0; px < 160; px++) begin
                setPix(px, py, (px + py) & 7);
                step();
                plotPixel = 1'b0;
                if (fb_we === 1'b1) writeCnt++;
                if (fb_we !== 1'b1 || fb_addr !== expAddr[14:0] ||
                    fb_data !== 3'((px + py) & 7)) addrBad++;
                if (frameDone !== 1'b0) fdBad++;
                step();
                if (frameDone === 1'b1) fdCnt++;
                if (frameDone !== (expAddr == 19199)) fdBad++;
                if (fb_we !== 1'b0) addrBad++;
                expAddr++;
            end
        end
        check("frame_writes",     writeCnt, 19200);
        check("frame_addr_order", addrBad,  0);
        check("frame_done_count", fdCnt,    1);
        check("frame_done_place", fdBad,    0);
        check("frame_overflow",   overflow, 0);

        // Back-pressure: five plots into a four-entry FIFO
        doReset();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setPix(i, 0, i + 1);
            step();
            check("bp_hold_addr", fb_addr, 0);
            check("bp_hold_data", fb_data, 1);
        end
        plotPixel = 1'b0;
        check("bp_we",        fb_we,     1);
        check("bp_overflow",  overflow,  1);
        check("bp_dropCount", dropCount, 1);
        step();
        check("bp_stable_we", fb_we, 1);
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_we",   fb_we,   1);
            check("bp_drain_addr", fb_addr, i);
            check("bp_drain_data", fb_data, i + 1);
            step();
        end
        check("bp_drained", fb_we, 0);

        // Clear status, then push and pop while full
        clearStatus = 1'b1;
        step();
        clearStatus = 1'b0;
        check("clr_overflow",  overflow,  0);
        check("clr_dropCount", dropCount, 0);
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setPix(10 + i, 1, i);
            step();
        end
        fb_ready = 1'b1;
        setPix(20, 1, 7);
        step();
        plotPixel = 1'b0;
        check("pp_overflow", overflow,  0);
        check("pp_drops",    dropCount, 0);
        check("pp_head",     fb_addr,   171);
        // Still full: one more plot without a pop must be lost
        fb_ready = 1'b0;
        setPix(30, 1, 1);
        step();
        plotPixel = 1'b0;
        check("pp_full_overflow", overflow,  1);
        check("pp_full_drops",    dropCount, 1);
        fb_ready = 1'b1;
        check("pp_drain0", fb_addr, 171);
        step();
        check("pp_drain1", fb_addr, 172);
        step();
        check("pp_drain2", fb_addr, 173);
        step();
        check("pp_drain3", fb_addr, 180);
        check("pp_drain3_data", fb_data, 7);
        step();
        check("pp_empty", fb_we, 0);

        // Range and saturation
        doReset();
        fb_ready = 1'b1;
        setPix(160, 0, 1);
        step();
        check("oor_x_we", fb_we, 0);
        setPix(0, 120, 1);
        step();
        plotPixel = 1'b0;
        check("oor_y_we",       fb_we,     0);
        check("oor_drops",      dropCount, 2);
        check("oor_overflow",   overflow,  0);
        spurious = 0;
        for (int i = 0; i < 300; i++) begin
            setPix(200 + (i % 50), i % 256, 2);
            step();
            if (fb_we !== 1'b0) spurious++;
        end
        plotPixel = 1'b0;
        check("sat_no_writes", spurious,  0);
        check("sat_drops",     dropCount, 255);
        setPix(0, 120, 0);
        clearStatus = 1'b1;
        step();
        plotPixel = 1'b0;
        check("clr_drop_wins", dropCount, 1);
        step();
        clearStatus = 1'b0;
        check("clr_to_zero", dropCount, 0);

        // Reset mid-stream, with the frame-final pixel pending
        fb_ready = 1'b0;
        setPix(159, 119, 6);
        step();
        setPix(1, 1, 1);
        step();
        setPix(2, 2, 2);
        step();
        plotPixel = 1'b0;
        check("mid_we",   fb_we,   1);
        check("mid_addr", fb_addr, 19199);
        check("mid_data", fb_data, 6);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_we",    fb_we,     0);
        check("mid_rst_addr",  fb_addr,   0);
        check("mid_rst_data",  fb_data,   0);
        check("mid_rst_fdone", frameDone, 0);
        step();
        resetn   = 1'b1;
        fb_ready = 1'b1;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fb_we !== 1'b0 || frameDone !== 1'b0) spurious++;
        end
        check("mid_quiet", spurious, 0);
        setPix(5, 5, 2);
        step();
        plotPixel = 1'b0;
        check("mid_new_we",   fb_we,   1);
        check("mid_new_addr", fb_addr, 805);
        check("mid_new_data", fb_data, 2);
        step();
        check("mid_new_done", fb_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
